// File: rtl/guess_entry_if.sv
// guess_entry_if: guess handoff bus between guess_entry (master) and game_core (slave).
//   guess_digits  packed guess, slot 0 in LSBs (master -> slave)
//   guess_valid   guess_digits holds a submitted guess (master -> slave)
//   guess_ready   core accepts the guess this cycle (slave -> master)
interface guess_entry_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
);
    logic [NUM_DIGITS*DIGIT_W-1:0] guess_digits;
    logic                          guess_valid;
    logic                          guess_ready;
    modport master (output guess_digits, guess_valid, input guess_ready);
    modport slave  (input guess_digits, guess_valid, output guess_ready);
endinterface

// File: rtl/guess_entry.sv
// guess_entry: assembles a NUM_DIGITS-digit guess from the switch encoder and
// hands it to the core over a valid/ready handshake.
// Optional feature macro: GUESS_DUP_CHECK_EN (reject digits already stored).
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   enable, clear  core in guess-input state / synchronous abort of entry
//   sw_val/valid   encoded switch digit and its qualifier
//   confirm_pulse  store digit (ENTRY) or submit (FULL)
//   delete_pulse   remove last stored digit
//   digit_count    digits stored so far
//   used_mask      bit d set while digit d is stored
//   reject_pulse   one-cycle pulse when a confirm is refused
//   entry_state    IDLE=0, ENTRY=1, FULL=2, HANDOFF=3
//   bus            guess_digits / guess_valid / guess_ready handshake
module guess_entry #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int MAX_DIGIT  = 9
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             clear,
    input  logic [DIGIT_W-1:0]               sw_val,
    input  logic                             sw_valid,
    input  logic                             confirm_pulse,
    input  logic                             delete_pulse,
    output logic [$clog2(NUM_DIGITS+1)-1:0]  digit_count,
    output logic [MAX_DIGIT:0]               used_mask,
    output logic                             reject_pulse,
    output logic [1:0]                       entry_state,
    guess_entry_if.master                    bus
);
    localparam int CW = $clog2(NUM_DIGITS+1);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int MW = MAX_DIGIT + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ENTRY = 2'd1, FULL = 2'd2, HANDOFF = 2'd3} state_t;

    state_t             state;
    logic [DIGIT_W-1:0] slots [NUM_DIGITS];
    logic [IW-1:0]      wr_idx, del_idx;
    logic [DIGIT_W-1:0] del_digit;
    logic [MW-1:0]      sw_bit, del_bit;
    logic               legal, del_shared;

    assign entry_state = state;
    assign wr_idx      = IW'(digit_count);
    assign del_idx     = IW'(digit_count - 1'b1);
    assign del_digit   = slots[del_idx];
    assign sw_bit      = MW'(1) << sw_val;
    assign del_bit     = MW'(1) << del_digit;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_pack
        assign bus.guess_digits[g*DIGIT_W +: DIGIT_W] = slots[g];
    end

`ifdef GUESS_DUP_CHECK_EN
    assign legal      = sw_valid && sw_val <= DIGIT_W'(MAX_DIGIT) && !(|(used_mask & sw_bit));
    assign del_shared = 1'b0;
`else
    assign legal = sw_valid && sw_val <= DIGIT_W'(MAX_DIGIT);
    // With repeats allowed, a deleted digit's mask bit survives if a lower slot still holds it.
    always_comb begin
        del_shared = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (CW'(i) < digit_count - 1'b1 && slots[i] == del_digit) del_shared = 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            digit_count     <= '0;
            used_mask       <= '0;
            slots           <= '{default: '0};
            bus.guess_valid <= 1'b0;
            reject_pulse    <= 1'b0;
        end else begin
            reject_pulse <= 1'b0;
            if (clear || !enable) begin
                state           <= enable ? ENTRY : IDLE;
                digit_count     <= '0;
                used_mask       <= '0;
                slots           <= '{default: '0};
                bus.guess_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= ENTRY;
                    ENTRY, FULL: begin
                        if (delete_pulse && digit_count != '0) begin
                            digit_count    <= digit_count - 1'b1;
                            slots[del_idx] <= '0;
                            if (!del_shared) used_mask <= used_mask & ~del_bit;
                            state <= ENTRY;
                        end else if (confirm_pulse) begin
                            if (state == FULL) begin
                                state           <= HANDOFF;
                                bus.guess_valid <= 1'b1;
                            end else if (legal) begin
                                slots[wr_idx] <= sw_val;
                                used_mask     <= used_mask | sw_bit;
                                digit_count   <= digit_count + 1'b1;
                                if (digit_count == CW'(NUM_DIGITS-1)) state <= FULL;
                            end else begin
                                reject_pulse <= 1'b1;
                            end
                        end
                    end
                    HANDOFF: begin
                        if (bus.guess_valid && bus.guess_ready) begin
                            state           <= ENTRY;
                            digit_count     <= '0;
                            used_mask       <= '0;
                            slots           <= '{default: '0};
                            bus.guess_valid <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_guess_entry.sv
// tb_guess_entry: directed and random stimulus for guess_entry, checked against a queue-based model.
module tb_guess_entry;
`ifdef GUESS_DUP_CHECK_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif
    logic       clk = 1'b0, reset = 1'b1, enable = 1'b0, clear = 1'b0;
    logic       sw_valid = 1'b0, confirm_pulse = 1'b0, delete_pulse = 1'b0;
    logic [3:0] sw_val = '0;
    logic [2:0] digit_count;
    logic [9:0] used_mask;
    logic       reject_pulse;
    logic [1:0] entry_state;
    int checks = 0, failures = 0;
    int m_st = 0;
    int q[$];
    bit m_vld = 0, m_rej = 0;

    guess_entry_if #(.NUM_DIGITS(4), .DIGIT_W(4)) gi();

    guess_entry #(.NUM_DIGITS(4), .DIGIT_W(4), .MAX_DIGIT(9)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .sw_val(sw_val), .sw_valid(sw_valid),
        .confirm_pulse(confirm_pulse), .delete_pulse(delete_pulse),
        .digit_count(digit_count), .used_mask(used_mask),
        .reject_pulse(reject_pulse), .entry_state(entry_state), .bus(gi)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit has(int d);
        foreach (q[i]) if (q[i] == d) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_step();
        m_rej = 1'b0;
        if (clear || !enable) begin
            m_st = enable ? 1 : 0;
            q.delete();
            m_vld = 1'b0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1 || m_st == 2) begin
            if (delete_pulse && q.size() > 0) begin
                void'(q.pop_back());
                m_st = 1;
            end else if (confirm_pulse && m_st == 2) begin
                m_st = 3;
                m_vld = 1'b1;
            end else if (confirm_pulse) begin
                if (sw_valid && sw_val <= 9 && !(DUP && has(int'(sw_val)))) begin
                    q.push_back(int'(sw_val));
                    if (q.size() == 4) m_st = 2;
                end else m_rej = 1'b1;
            end
        end else if (gi.guess_ready) begin
            q.delete();
            m_st = 1;
            m_vld = 1'b0;
        end
    endfunction

    task automatic compare_all(string tag);
        logic [15:0] d = '0;
        logic [9:0]  m = '0;
        foreach (q[i]) begin
            d |= 16'(q[i]) << (4 * i);
            m |= 10'(1) << q[i];
        end
        chk({tag, ".digits"}, 64'(gi.guess_digits), 64'(d));
        chk({tag, ".count"},  64'(digit_count), 64'(q.size()));
        chk({tag, ".mask"},   64'(used_mask), 64'(m));
        chk({tag, ".valid"},  64'(gi.guess_valid), 64'(m_vld));
        chk({tag, ".reject"}, 64'(reject_pulse), 64'(m_rej));
        chk({tag, ".state"},  64'(entry_state), 64'(m_st));
    endtask

    task automatic step(string tag, bit cf = 0, bit dl = 0, logic [3:0] s = 0, bit v = 1, bit rd = 0);
        confirm_pulse  = cf;
        delete_pulse   = dl;
        sw_val         = s;
        sw_valid       = v;
        gi.guess_ready = rd;
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        gi.guess_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        reset = 1'b0;
        // basic entry and handoff
        enable = 1'b1;
        step("idle2entry");
        step("d1", 1, 0, 4'd1);
        step("d2", 1, 0, 4'd2);
        step("d3", 1, 0, 4'd3);
        step("d4", 1, 0, 4'd4);
        chk("full_state", 64'(entry_state), 64'd2);
        step("submit", 1, 0, 4'd0, 0);
        chk("guess_value", 64'(gi.guess_digits), 64'h4321);
        chk("guess_mask", 64'(used_mask), 64'h01E);
        step("hold");
        chk("hold_valid", 64'(gi.guess_valid), 64'd1);
        step("accept", 0, 0, 4'd0, 1, 1);
        chk("accept_count", 64'(digit_count), 64'd0);
        // duplicate handling
        step("dup_a", 1, 0, 4'd5);
        step("dup_b", 1, 0, 4'd5);
        chk("dup_count", 64'(digit_count), DUP ? 64'd1 : 64'd2);
        chk("dup_reject", 64'(reject_pulse), DUP ? 64'd1 : 64'd0);
        step("dup_after");
        clear = 1'b1;
        step("clear1");
        clear = 1'b0;
        // illegal switch values
        step("no_valid", 1, 0, 4'd3, 0);
        chk("no_valid_rej", 64'(reject_pulse), 64'd1);
        step("val12", 1, 0, 4'd12);
        chk("val12_rej", 64'(reject_pulse), 64'd1);
        // delete from FULL and delete/confirm collision
        step("e7", 1, 0, 4'd7);
        step("e8", 1, 0, 4'd8);
        step("e9", 1, 0, 4'd9);
        step("e0", 1, 0, 4'd0);
        step("del_full", 0, 1);
        chk("del_full_mask", 64'(used_mask), 64'h380);
        chk("del_full_state", 64'(entry_state), 64'd1);
        step("both", 1, 1, 4'd5);
        chk("both_count", 64'(digit_count), 64'd2);
        // enable drop during handoff
        step("f1", 1, 0, 4'd1);
        step("f2", 1, 0, 4'd2);
        step("f_sub", 1);
        chk("f_valid", 64'(gi.guess_valid), 64'd1);
        enable = 1'b0;
        step("en_drop");
        chk("en_drop_state", 64'(entry_state), 64'd0);
        enable = 1'b1;
        // random traffic
        repeat (400) begin
            enable = $urandom_range(0, 19) != 0;
            clear  = $urandom_range(0, 29) == 0;
            step("rand", $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                 4'($urandom_range(0, 11)), $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
        end
        // async reset mid-handoff
        enable = 1'b1;
        clear  = 1'b1;
        step("pre_clear");
        clear = 1'b0;
        step("r1", 1, 0, 4'd1);
        step("r2", 1, 0, 4'd2);
        step("r3", 1, 0, 4'd3);
        step("r4", 1, 0, 4'd4);
        step("r_sub", 1);
        chk("r_valid", 64'(gi.guess_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 64'(gi.guess_valid), 64'd0);
        chk("arst_digits", 64'(gi.guess_digits), 64'd0);
        chk("arst_count", 64'(digit_count), 64'd0);
        chk("arst_mask", 64'(used_mask), 64'd0);
        chk("arst_state", 64'(entry_state), 64'd0);
        q.delete();
        m_st = 0;
        m_vld = 1'b0;
        m_rej = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("post_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
